// File: rtl/wav_fetch_cache_pkg.sv
// rtl/wav_fetch_cache_pkg.sv - shared FSM states and index helpers for the wave-fetch cache
package wav_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_WAIT,
        S_FILL,
        S_PREFETCH,
        S_PWAIT
    } state_t;

    // Byte address bit 0 selects a byte inside the 16-bit word and is never used.
    localparam int WORD_LSB = 1;

    // log2 of the line count (LINES is a power of two, 2..16).
    function automatic int idx_bits(input int lines);
        int b;
        b = 0;
        for (int i = 0; i < 5; i++) begin
            if ((1 << i) < lines) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/wav_fetch_cache_if.sv
// rtl/wav_fetch_cache_if.sv - sample-player request and SDRAM read bus of the wave-fetch cache
// Signals:
//   req/req_addr        client read request level and byte address
//   rsp_valid/rsp_data  one-cycle response pulse and the returned word
//   sd_rd/sd_addr       one-cycle SDRAM read strobe and word address
//   sd_dout/sd_ready    SDRAM read data and its one-cycle valid pulse
// Modports: master = client plus SDRAM controller side, slave = the cache.
interface wav_fetch_cache_if #(
    parameter int ADDR_W = 25
);
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic              sd_rd;
    logic [ADDR_W-1:0] sd_addr;
    logic [15:0]       sd_dout;
    logic              sd_ready;

    modport master (
        output req, req_addr, sd_dout, sd_ready,
        input  rsp_valid, rsp_data, sd_rd, sd_addr
    );

    modport slave (
        input  req, req_addr, sd_dout, sd_ready,
        output rsp_valid, rsp_data, sd_rd, sd_addr
    );
endinterface

// File: rtl/wav_fetch_cache_sat_counter16.sv
// rtl/wav_fetch_cache_sat_counter16.sv - 16-bit event counter that sticks at 0xFFFF
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous clear
//   en          count one event this cycle
//   cnt         current count
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wav_fetch_cache.sv
// rtl/wav_fetch_cache.sv - direct-mapped word cache and single-outstanding SDRAM read sequencer
// Ports:
//   CLK, RESET_N  video clock and asynchronous active-low reset
//   dl_active     download in progress: invalidate everything and keep off the SDRAM port
//   bus           request/response and SDRAM read signals (slave side)
//   hit_cnt       saturating lookup hit count
//   miss_cnt      saturating lookup miss count
module wav_fetch_cache
    import wav_fetch_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int LINES    = 4,
    parameter bit PREFETCH = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               dl_active,
    wav_fetch_cache_if.slave   bus,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
);

    localparam int WW = ADDR_W - WORD_LSB;
    localparam int IB = idx_bits(LINES);
    localparam int TW = WW - IB;

    state_t          state;
    logic [WW-1:0]   cur_w;
    logic [15:0]     line_data [LINES];
    logic [TW-1:0]   line_tag  [LINES];
    logic [LINES-1:0] line_valid;

    logic [WW-1:0]   req_w;
    logic [WW-1:0]   next_w;
    logic [IB-1:0]   cur_idx;
    logic [IB-1:0]   next_idx;
    logic [TW-1:0]   cur_tag;
    logic [TW-1:0]   next_tag;
    logic            cur_hit;
    logic            next_cached;
    logic            hit_en;
    logic            miss_en;
    logic            unused_byte_sel;

    assign req_w           = bus.req_addr[ADDR_W-1:WORD_LSB];
    assign unused_byte_sel = bus.req_addr[0];

    // Word index wraps naturally at the top of the address space.
    assign next_w   = cur_w + WW'(1);
    assign cur_idx  = cur_w[IB-1:0];
    assign cur_tag  = cur_w[WW-1:IB];
    assign next_idx = next_w[IB-1:0];
    assign next_tag = next_w[WW-1:IB];

    assign cur_hit     = line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
    assign next_cached = line_valid[next_idx] && (line_tag[next_idx] == next_tag);

    assign hit_en  = (state == S_LOOKUP) && !dl_active && cur_hit;
    assign miss_en = (state == S_LOOKUP) && !dl_active && !cur_hit;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            cur_w         <= '0;
            line_valid    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.sd_rd     <= 1'b0;
            bus.sd_addr   <= '0;
            for (int i = 0; i < LINES; i++) begin
                line_data[i] <= '0;
                line_tag[i]  <= '0;
            end
        end else begin
            // Both strobes are single-cycle pulses.
            bus.rsp_valid <= 1'b0;
            bus.sd_rd     <= 1'b0;
            if (dl_active) begin
                // Loader owns SDRAM; any read still in flight is abandoned.
                state      <= S_IDLE;
                line_valid <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Skip the cycle right after a response so one request is served once.
                        if (bus.req && !bus.rsp_valid) begin
                            cur_w <= req_w;
                            state <= S_LOOKUP;
                        end
                    end
                    S_LOOKUP: begin
                        if (cur_hit) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= line_data[cur_idx];
                            state         <= S_IDLE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        bus.sd_rd   <= 1'b1;
                        bus.sd_addr <= {cur_w, {WORD_LSB{1'b0}}};
                        state       <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.sd_ready) begin
                            line_data[cur_idx]  <= bus.sd_dout;
                            line_tag[cur_idx]   <= cur_tag;
                            line_valid[cur_idx] <= 1'b1;
                            bus.rsp_valid       <= 1'b1;
                            bus.rsp_data        <= bus.sd_dout;
                            state               <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (PREFETCH && !next_cached) begin
                            bus.sd_rd   <= 1'b1;
                            bus.sd_addr <= {next_w, {WORD_LSB{1'b0}}};
                            state       <= S_PREFETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PREFETCH: begin
                        state <= S_PWAIT;
                    end
                    S_PWAIT: begin
                        if (bus.sd_ready) begin
                            line_data[next_idx]  <= bus.sd_dout;
                            line_tag[next_idx]   <= next_tag;
                            line_valid[next_idx] <= 1'b1;
                            state                <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter16 u_hit_cnt (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clear (1'b0),
        .en    (hit_en),
        .cnt   (hit_cnt)
    );

    sat_counter16 u_miss_cnt (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clear (1'b0),
        .en    (miss_en),
        .cnt   (miss_cnt)
    );

endmodule

// File: doc/wav_fetch_cache.md
# wav_fetch_cache

Word cache and SDRAM read sequencer between the sample player's wave-fetch port and the SDRAM controller, both in the 43.264 MHz video clock domain. It takes byte-addressed read requests from the sample player and returns the 16-bit word holding that byte. It serves hits from a small direct-mapped cache and misses through a single-outstanding SDRAM read, with optional next-word prefetch. During ROM/WAV download it invalidates itself and blocks all SDRAM reads, so loader writes own the SDRAM port.

## Interface
- ADDR_W, 25, byte-address width (matches ioctl_addr).
- LINES, 4, cache lines (one 16-bit word each); power of two, 2..16.
- PREFETCH, 1, 1 = fetch word+1 after each miss fill.

Ports:
- CLK  in  1  single clock (clk_vid); every register is in this domain.
- RESET_N  in  1  asynchronous, active-low reset.
- dl_active  in  1  download in progress (ioctl_download).
- req  in  1  read request level; client holds it until rsp_valid.
- req_addr  in  ADDR_W  byte address; bit 0 ignored. Must be stable while req is high.
- rsp_valid  out  1  one-cycle pulse: rsp_data is valid.
- rsp_data  out  16  word at {req_addr[ADDR_W-1:1],0}; holds its value until the next rsp_valid.
- sd_rd  out  1  one-cycle SDRAM read strobe.
- sd_addr  out  ADDR_W  SDRAM word address, bit 0 = 0.
- sd_dout  in  16  SDRAM read data, valid when sd_ready = 1.
- sd_ready  in  1  one-cycle pulse: read data available.
- hit_cnt  out  16  saturating hit counter.
- miss_cnt  out  16  saturating miss counter.

## Operation
- Word index w = req_addr[ADDR_W-1:1]. Line = w[log2(LINES)-1:0]. Tag = remaining upper bits of w. Each line has a valid bit.
- FSM states: IDLE, LOOKUP, FETCH, WAIT, FILL, PREFETCH, PWAIT.
- IDLE: if req=1 and dl_active=0 and no rsp_valid was issued in the previous cycle, go to LOOKUP.
- LOOKUP, hit: rsp_valid=1, rsp_data=line data, hit_cnt+1, go to IDLE.
- LOOKUP, miss: miss_cnt+1, go to FETCH.
- FETCH: sd_rd=1 for exactly one cycle, sd_addr={w,0}, go to WAIT.
- WAIT: on sd_ready, write sd_dout into the line, set its tag and valid bit, go to FILL.
- FILL: rsp_valid=1 with the filled word. Then go to PREFETCH if PREFETCH=1 and word w+1 is not already cached; otherwise go to IDLE.
- PREFETCH: issue a one-cycle sd_rd at {w+1,0}. w+1 wraps modulo 2^(ADDR_W-1): byte 0x1FFFFFE prefetches 0x0000000. Go to PWAIT.
- PWAIT: on sd_ready, fill the line, go to IDLE. A req arriving during PREFETCH/PWAIT waits and is looked up after the fill, so it can hit the prefetched word.
- Only one SDRAM read is outstanding at any time. sd_rd is never asserted in WAIT or PWAIT.
- sd_ready outside WAIT/PWAIT is ignored.
- dl_active=1, from any state:
  - next cycle: all valid bits cleared, FSM in IDLE, sd_rd=0, no rsp_valid.
  - requests ignored while dl_active stays high.
  - an in-flight sd_ready is discarded.
- Counters saturate at 0xFFFF. Download does not clear them; reset does.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, sd_rd=0, sd_addr=0, hit_cnt=0, miss_cnt=0, valid bits=0, FSM=IDLE.
- Hit latency: req high at edge N → rsp_valid at edge N+2 (IDLE→LOOKUP→response).
- Miss latency: sd_rd at N+3. sd_ready at edge M → rsp_valid at M+1.
- Prefetch sd_rd is asserted at M+2.
- Back-to-back: after rsp_valid the client drops req or changes req_addr. The block waits one IDLE cycle before sampling again, so it never responds twice to one request.
- Reset mid-fetch: all state clears. A late sd_ready after release is ignored, because the FSM is in IDLE.

## Structure
- Shared package wav_fetch_pkg holds:
  - FSM state enum.
  - function idx_bits(LINES) (log2).
  - constant WORD_LSB = 1.
- Cache storage: register arrays (data[LINES], tag[LINES], valid[LINES]), no RAM macro.
- One sub-module, sat_counter16 (enable, clear, saturating), instanced twice for hit_cnt and miss_cnt.

## Test plan
- Cold miss: req_addr=0x000104, sd_ready 5 cycles after sd_rd with sd_dout=0xBEEF → sd_addr=0x000104, rsp_valid one cycle after sd_ready with 0xBEEF, miss_cnt=1. Then prefetch sd_rd at 0x000106.
- Hit after fill: repeat req_addr=0x000105 → rsp_valid 2 cycles after req, data 0xBEEF, no sd_rd, hit_cnt=1.
- Prefetch hit: req_addr=0x000106 after the prefetch returns 0x1234 → hit, data 0x1234, no sd_rd.
- Conflict eviction, LINES=4: fill word 0x82 (byte 0x104), then read byte 0x10C (word 0x86, same line) → miss. Byte 0x104 read afterwards → miss again.
- Wrap: req_addr=0x1FFFFFE miss → prefetch sd_addr=0x0000000.
- Download abort: dl_active pulse during WAIT, stray sd_ready then arrives → no rsp_valid, sd_rd stays 0. The next req to the previously cached address misses.
